ripple_count_monitor: RTL

RIPPLE_COUNT_MONITOR -- requirements
Module: ripple_count_monitor

---
 rtl/ripple_count_monitor_pkg.sv | 15 +
 rtl/rcm_sync2.sv | 23 ++
 rtl/ripple_count_monitor.sv | 133 +++++++++++++
 3 files changed

// File: rtl/ripple_count_monitor_pkg.sv
// Shared types and defaults for the ripple count monitor.
// Defines the snapshot FSM states, the 4-bit count type and the default parameter values.
package ripple_count_monitor_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } snap_state_t;

    typedef logic [3:0] cnt4_t;

    localparam int DEF_EXT_W      = 16;
    localparam int DEF_STABLE_CYC = 2;

endpackage

// File: rtl/rcm_sync2.sv
// Two-flop synchronizer for the 4-bit rippling count.
// s1 is also exported so the stability logic can see an s2 change one edge in advance.
module rcm_sync2
    import ripple_count_monitor_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  cnt4_t d,
    output cnt4_t s1,
    output cnt4_t s2
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

endmodule

// File: rtl/ripple_count_monitor.sv
// Extends an asynchronous 4-bit ripple count into an EXT_W-bit count, with a snapshot handshake.
// Optional skip checking is enabled by defining RIPPLE_COUNT_MONITOR_SKIP_CHECK_EN.
module ripple_count_monitor
    import ripple_count_monitor_pkg::*;
#(
    parameter int EXT_W      = DEF_EXT_W,
    parameter int STABLE_CYC = DEF_STABLE_CYC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       cnt_in,
    input  logic             clr,
    input  logic             snap_req,
    output logic             snap_valid,
    input  logic             snap_ready,
    output logic [EXT_W-1:0] snap_data,
    output logic [EXT_W-1:0] count_ext,
    output logic             wrap_pulse,
    output logic             err_skip
);

    localparam logic [3:0] STAB_TGT = 4'(STABLE_CYC);

    cnt4_t            s1;
    cnt4_t            s2;
    cnt4_t            prev;
    cnt4_t            delta;
    logic [3:0]       stab;
    logic             acc_done;
    logic             base_valid;
    logic             accept;
    logic [EXT_W-1:0] delta_ext;
    snap_state_t      state_q;
    snap_state_t      state_d;
    logic             snap_load;

    rcm_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cnt_in),
        .s1    (s1),
        .s2    (s2)
    );

    // s1 != s2 means s2 takes a new value at this edge, so stab restarts at 1 alongside it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stab     <= '0;
            acc_done <= 1'b0;
        end else if (s1 != s2) begin
            stab     <= 4'd1;
            acc_done <= 1'b0;
        end else begin
            if (stab != 4'hf) stab <= stab + 4'd1;
            if (accept) acc_done <= 1'b1;
        end
    end

    assign accept    = (stab == STAB_TGT) && !acc_done;
    assign delta     = s2 - prev;
    assign delta_ext = {{(EXT_W-4){1'b0}}, delta};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev       <= '0;
            base_valid <= 1'b0;
            count_ext  <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            if (accept) begin
                prev       <= s2;
                base_valid <= 1'b1;
            end
            // clr wins over a same-cycle acceptance; prev above still follows s2.
            if (clr) begin
                count_ext <= '0;
            end else if (accept && base_valid) begin
                count_ext  <= count_ext + delta_ext;
                wrap_pulse <= (s2 < prev);
            end
        end
    end

`ifdef RIPPLE_COUNT_MONITOR_SKIP_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (clr) begin
            err_q <= 1'b0;
        end else if (accept && base_valid && (delta > 4'd1)) begin
            err_q <= 1'b1;
        end
    end

    assign err_skip = err_q;
`else
    assign err_skip = 1'b0;
`endif

    // Snapshot handshake: snap_valid is high exactly while in HOLD; transfer on snap_valid && snap_ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            snap_data <= '0;
        end else begin
            state_q <= state_d;
            if (snap_load) snap_data <= count_ext;
        end
    end

    always_comb begin
        state_d    = state_q;
        snap_load  = 1'b0;
        snap_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (snap_req) begin
                    snap_load = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                snap_valid = 1'b1;
                if (snap_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
